// File: rtl/bin2bcd_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin2bcd_if : start/operand request and BCD result bundle for bin2bcd
// Revision   : 1.0
// ----------------------------------------------------------------------------
interface bin2bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic                  signed_mode;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  negative;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, signed_mode, value,
        input  busy, done, negative, bcd
    );

    modport slave (
        input  start, signed_mode, value,
        output busy, done, negative, bcd
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin2bcd : sequential shift-and-add-3 binary to packed BCD, one bit per clock
// Revision: 1.0
// ----------------------------------------------------------------------------
module bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  wire logic   clock,
    input  wire logic   reset,
    bin2bcd_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [WIDTH-1:0]      r_mag;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CW-1:0]         r_cnt;
    logic                  r_sign;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_neg;
    logic                  r_done;

    logic                  w_load;
    logic                  w_step;
    logic                  w_commit;
    logic                  w_neg_in;
    logic [WIDTH-1:0]      w_mag_in;
    logic [4*DIGITS-1:0]   w_adj;

    // Two's-complement negation wraps, so the most negative input maps to 2^(WIDTH-1).
    assign w_neg_in = bus.signed_mode & bus.value[WIDTH-1];
    assign w_mag_in = w_neg_in ? (~bus.value + WIDTH'(1)) : bus.value;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                                 (r_scratch[4*k +: 4] + 4'd3) :
                                  r_scratch[4*k +: 4];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                w_step = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_commit     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mag     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
        end else if (w_load) begin
            r_mag     <= w_mag_in;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sign    <= w_neg_in;
        end else if (w_step) begin
            r_scratch <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
            r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
            r_cnt     <= r_cnt + CW'(1);
        end
    end

    // Results are only ever written whole, so the display never sees a partial value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_bcd <= r_scratch;
                r_neg <= r_sign;
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.negative = r_neg;
    assign bus.bcd      = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bin2bcd : directed self-checking bench for bin2bcd (WIDTH=16, DIGITS=5)
// Revision   : 1.0
// ----------------------------------------------------------------------------
module tb_bin2bcd;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) bif ();

    bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from a negedge and returns what the result looked like.
    task automatic run_conv(input logic [15:0] v, input logic s,
                            output logic [19:0] bcd, output logic neg,
                            output int lat, output int busy_cnt, output bit to);
        int n;
        bif.start       = 1'b1;
        bif.value       = v;
        bif.signed_mode = s;
        @(posedge clk);
        @(negedge clk);
        bif.start       = 1'b0;
        bif.value       = 16'($urandom);
        bif.signed_mode = 1'($urandom);
        n        = 1;
        busy_cnt = 0;
        while (!bif.done && n < 60) begin
            if (bif.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        to  = !bif.done;
        lat = n - 1;
        bcd = bif.bcd;
        neg = bif.negative;
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0;
        bif.start = 1'b0;
        bif.value = 16'h0;
        bif.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bif.busy, bif.done, bif.negative, bif.bcd} !== 23'h0) begin
            failures++;
            $display("FAIL reset_asserted: got busy=%0b done=%0b neg=%0b bcd=%05h, want all 0",
                     bif.busy, bif.done, bif.negative, bif.bcd);
        end
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({bif.busy, bif.done, bif.negative, bif.bcd} !== 23'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_hold: outputs left zero during 50 idle cycles, last busy=%0b done=%0b bcd=%05h",
                     bif.busy, bif.done, bif.bcd);
        end
    endtask

    task automatic test_unsigned();
        logic [19:0] bcd;
        logic neg;
        int lat, bc;
        bit to;
        run_conv(16'd0, 1'b0, bcd, neg, lat, bc, to);
        checks++;
        if (to || lat != 17 || bcd !== 20'h00000) begin
            failures++;
            $display("FAIL unsigned_zero: got bcd=%05h lat=%0d timeout=%0b, want bcd=00000 lat=17", bcd, lat, to);
        end
        run_conv(16'd65535, 1'b0, bcd, neg, lat, bc, to);
        checks++;
        if (to || bcd !== 20'h65535 || neg !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_max: got bcd=%05h neg=%0b timeout=%0b, want bcd=65535 neg=0", bcd, neg, to);
        end
        checks++;
        if (lat != 17 || bc != 17) begin
            failures++;
            $display("FAIL unsigned_timing: got latency=%0d busy_cycles=%0d, want 17 and 17", lat, bc);
        end
        checks++;
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done: got busy=%0b in done cycle, want 0", bif.busy);
        end
        @(negedge clk);
        checks++;
        if (bif.done !== 1'b0 || bif.bcd !== 20'h65535) begin
            failures++;
            $display("FAIL done_width: got done=%0b bcd=%05h one cycle later, want done=0 bcd=65535",
                     bif.done, bif.bcd);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vals [5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        logic        sms  [5] = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b1};
        logic [19:0] exps [5] = '{20'h32768, 20'h00001, 20'h32767, 20'h32768, 20'h00000};
        logic        negs [5] = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
        logic [19:0] bcd;
        logic neg;
        int lat, bc;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_conv(vals[i], sms[i], bcd, neg, lat, bc, to);
            checks++;
            if (to || bcd !== exps[i] || neg !== negs[i]) begin
                failures++;
                $display("FAIL signed_%0d: value=%04h sm=%0b got bcd=%05h neg=%0b timeout=%0b, want bcd=%05h neg=%0b",
                         i, vals[i], sms[i], bcd, neg, to, exps[i], negs[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        int n, extra;
        bit to;
        bif.start = 1'b1;
        bif.value = 16'd1234;
        bif.signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
        n = 1;
        while (!bif.done && n < 60) begin
            if (n == 6) begin
                bif.start = 1'b1;
                bif.value = 16'd9;
            end else begin
                bif.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bif.start = 1'b0;
        to = !bif.done;
        checks++;
        if (to || n - 1 != 17 || bif.bcd !== 20'h01234) begin
            failures++;
            $display("FAIL start_busy_result: got bcd=%05h latency=%0d timeout=%0b, want bcd=01234 latency=17",
                     bif.bcd, n - 1, to);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.done || bif.busy) extra++;
        end
        checks++;
        if (extra != 0 || bif.bcd !== 20'h01234) begin
            failures++;
            $display("FAIL start_busy_ignored: got %0d busy/done cycles afterwards, bcd=%05h, want 0 and 01234",
                     extra, bif.bcd);
        end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        bit to;
        bif.start = 1'b1;
        bif.value = 16'd1234;
        bif.signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!bif.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        to = !bif.done;
        checks++;
        if (to || bif.bcd !== 20'h01234) begin
            failures++;
            $display("FAIL b2b_first: got bcd=%05h timeout=%0b, want bcd=01234", bif.bcd, to);
        end
        bif.value = 16'd9;
        @(negedge clk);
        bif.start = 1'b0;
        gap = 1;
        while (!bif.done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        to = !bif.done;
        checks++;
        if (to || gap != 18 || bif.bcd !== 20'h00009) begin
            failures++;
            $display("FAIL b2b_second: got gap=%0d bcd=%05h timeout=%0b, want gap=18 bcd=00009", gap, bif.bcd, to);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [19:0] bcd;
        logic neg;
        int lat, bc, dones;
        bit to;
        bif.start = 1'b1;
        bif.value = 16'd4321;
        bif.signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.bcd !== 20'h00000 || bif.negative !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_immediate: got busy=%0b done=%0b neg=%0b bcd=%05h, want all 0",
                     bif.busy, bif.done, bif.negative, bif.bcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.done || bif.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_abort: got %0d busy/done cycles after reset, want 0", dones);
        end
        run_conv(16'd77, 1'b0, bcd, neg, lat, bc, to);
        checks++;
        if (to || bcd !== 20'h00077 || neg !== 1'b0 || lat != 17) begin
            failures++;
            $display("FAIL reset_mid_restart: got bcd=%05h neg=%0b lat=%0d timeout=%0b, want bcd=00077 neg=0 lat=17",
                     bcd, neg, lat, to);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
